// File: rtl/apb_irq_ctrl_pkg.sv
// Shared definitions for the APB interrupt controller: register offsets,
// the register-select type and the claim priority encoder.
package irq_ctrl_pkg;

  localparam int MAX_SRC = 31;

  // Byte offsets of the registers; only address bits [4:2] are decoded.
  localparam logic [4:0] IRQC_PENDING = 5'h00;
  localparam logic [4:0] IRQC_ENABLE  = 5'h04;
  localparam logic [4:0] IRQC_TRIG    = 5'h08;
  localparam logic [4:0] IRQC_CLAIM   = 5'h0C;
  localparam logic [4:0] IRQC_SWSET   = 5'h10;

  typedef enum logic [2:0] {
    REG_PENDING,
    REG_ENABLE,
    REG_TRIG,
    REG_CLAIM,
    REG_SWSET,
    REG_NONE
  } reg_sel_e;

  // Map the word index (address bits [4:2]) onto a register select.
  function automatic reg_sel_e decode_reg(input logic [2:0] word);
    logic [4:0] off;
    off = {word, 2'b00};
    case (off)
      IRQC_PENDING: return REG_PENDING;
      IRQC_ENABLE:  return REG_ENABLE;
      IRQC_TRIG:    return REG_TRIG;
      IRQC_CLAIM:   return REG_CLAIM;
      IRQC_SWSET:   return REG_SWSET;
      default:      return REG_NONE;
    endcase
  endfunction

  // Returns index+1 of the lowest set bit, or 0 when the vector is empty.
  function automatic logic [4:0] lowest_set_id(input logic [MAX_SRC-1:0] vec);
    logic [4:0] id;
    id = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) id = 5'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/apb_irq_ctrl_if.sv
// APB3 slave-side bus bundle for the interrupt controller.
interface apb_irq_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/irq_src_gate.sv
// Per-source request latch: optional 2-flop synchroniser (APB_IRQC_SYNC_EN),
// previous-value register, edge/level select and the pending flop.
// A set on the same edge as a clear wins, so a still-active source re-pends.
module irq_src_gate (
  input  logic clock,
  input  logic reset,
  input  logic src_raw,
  input  logic trig,     // 1 = edge, 0 = level
  input  logic sw_set,
  input  logic clr,
  output logic pending
);

  logic src_s;

`ifdef APB_IRQC_SYNC_EN
  logic [1:0] sync_reg;

  // Two-flop synchroniser for an asynchronous request line.
  always_ff @(posedge clock) begin
    if (reset) sync_reg <= '0;
    else       sync_reg <= {sync_reg[0], src_raw};
  end

  assign src_s = sync_reg[1];
`else
  assign src_s = src_raw;
`endif

  logic src_q_reg;
  logic pending_reg;
  logic hw_set;
  logic pending_next;

  assign hw_set       = trig ? (src_s & ~src_q_reg) : src_s;
  assign pending_next = (pending_reg & ~clr) | hw_set | sw_set;

  // Previous-cycle source value and the pending latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_q_reg   <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      src_q_reg   <= src_s;
      pending_reg <= pending_next;
    end
  end

  assign pending = pending_reg;

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB3 interrupt controller: latches edge/level requests, masks them and
// drives one registered irq line; reading CLAIM returns and clears the
// lowest-index pending+enabled source. Optional macro APB_IRQC_SYNC_EN adds
// a 2-flop synchroniser on every src_i bit.
module apb_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int ADDR_W  = 12
) (
  input  logic               clock,
  input  logic               reset,
  apb_irq_ctrl_if.slave      apb,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               irq_o
);

  logic [ADDR_W-1:0]  paddr;
  logic               access;
  reg_sel_e           reg_sel;
  logic               slv_err;
  logic               wr_ok;
  logic               rd_ok;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable_reg;
  logic [NUM_SRC-1:0] trig_reg;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] sw_set;
  logic [MAX_SRC-1:0] claim_vec;
  logic [4:0]         claim_id;
  logic               claim_fire;
  logic               irq_reg;
  logic [31:0]        prdata;
  logic               unused_bits;

  assign paddr   = apb.PADDR;
  assign access  = apb.PSEL & apb.PENABLE;
  assign reg_sel = decode_reg(paddr[4:2]);

  // Bus error: unmapped offset, write to a read-only register, read of SWSET.
  always_comb begin
    slv_err = 1'b0;
    if (access) begin
      case (reg_sel)
        REG_NONE:                slv_err = 1'b1;
        REG_PENDING, REG_CLAIM:  slv_err = apb.PWRITE;
        REG_SWSET:               slv_err = ~apb.PWRITE;
        default:                 slv_err = 1'b0;
      endcase
    end
  end

  assign wr_ok = access & apb.PWRITE & ~slv_err;
  assign rd_ok = access & ~apb.PWRITE & ~slv_err;

  // Widen the masked pending set to the encoder's fixed width.
  always_comb begin
    claim_vec                = '0;
    claim_vec[NUM_SRC-1:0]   = pending & enable_reg;
  end

  assign claim_id   = lowest_set_id(claim_vec);
  assign claim_fire = rd_ok & (reg_sel == REG_CLAIM) & (claim_id != 5'd0);
  assign sw_set     = (wr_ok && reg_sel == REG_SWSET) ? apb.PWDATA[NUM_SRC-1:0] : '0;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign clr[gi] = claim_fire & (claim_id == 5'(gi + 1));

      irq_src_gate u_gate (
        .clock   (clock),
        .reset   (reset),
        .src_raw (src_i[gi]),
        .trig    (trig_reg[gi]),
        .sw_set  (sw_set[gi]),
        .clr     (clr[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  // Software-writable mask and trigger-mode registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      enable_reg <= '0;
      trig_reg   <= '0;
    end else if (wr_ok) begin
      if (reg_sel == REG_ENABLE) enable_reg <= apb.PWDATA[NUM_SRC-1:0];
      if (reg_sel == REG_TRIG)   trig_reg   <= apb.PWDATA[NUM_SRC-1:0];
    end
  end

  // Registered interrupt output from the current masked pending set.
  always_ff @(posedge clock) begin
    if (reset) irq_reg <= 1'b0;
    else       irq_reg <= |(pending & enable_reg);
  end

  // Combinational read data, zero outside a successful read access.
  always_comb begin
    prdata = '0;
    if (rd_ok) begin
      case (reg_sel)
        REG_PENDING: prdata[NUM_SRC-1:0] = pending;
        REG_ENABLE:  prdata[NUM_SRC-1:0] = enable_reg;
        REG_TRIG:    prdata[NUM_SRC-1:0] = trig_reg;
        REG_CLAIM:   prdata[4:0]         = claim_id;
        default:     prdata              = '0;
      endcase
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = slv_err;
  assign irq_o       = irq_reg;

  // Address bits outside [4:2] and write-data bits above NUM_SRC are ignored.
  assign unused_bits = ^{paddr, apb.PWDATA};

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Self-checking bench for apb_irq_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the register/pending rules.
// Honours APB_IRQC_SYNC_EN (extra two cycles of request latency).
module tb_apb_irq_ctrl;

  localparam int NUM_SRC = 5;
  localparam int ADDR_W  = 12;
`ifdef APB_IRQC_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] src_i;
  logic               irq_o;

  apb_irq_ctrl_if #(.ADDR_W(ADDR_W)) apb ();

  apb_irq_ctrl #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .apb   (apb),
    .src_i (src_i),
    .irq_o (irq_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [NUM_SRC-1:0] m_pend, m_en, m_trig, m_prev;
  logic               m_irq;
  logic [NUM_SRC-1:0] m_dly[$];   // request delay line (synchroniser depth)

  function automatic logic [31:0] m_claim();
    for (int i = 0; i < NUM_SRC; i++)
      if (m_pend[i] && m_en[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  // Expected read data / error for an access at the current model state.
  function automatic void model_access(input logic wr, input logic [ADDR_W-1:0] addr,
                                       output logic [31:0] rd, output logic err);
    int w;
    w   = int'(addr[4:2]);
    rd  = '0;
    err = 1'b0;
    if (w > 4) err = 1'b1;
    else if (wr && (w == 0 || w == 3)) err = 1'b1;
    else if (!wr && w == 4) err = 1'b1;
    if (!err && !wr) begin
      case (w)
        0: rd = 32'(m_pend);
        1: rd = 32'(m_en);
        2: rd = 32'(m_trig);
        3: rd = m_claim();
        default: rd = '0;
      endcase
    end
  endfunction

  // Advance the model over one clock edge using the inputs now applied,
  // then let the DUT take the edge and settle.
  task automatic step();
    logic [NUM_SRC-1:0] eff, hw, clr, sw;
    logic [31:0] rd;
    logic err, nirq;
    int w;
    if (reset) begin
      m_pend = '0; m_en = '0; m_trig = '0; m_prev = '0; m_irq = 1'b0;
      m_dly.delete();
      repeat (SYNC_DEPTH) m_dly.push_back('0);
    end else begin
      m_dly.push_back(src_i);
      eff = m_dly.pop_front();
      for (int i = 0; i < NUM_SRC; i++)
        hw[i] = m_trig[i] ? (eff[i] & ~m_prev[i]) : eff[i];
      nirq = |(m_pend & m_en);
      clr = '0;
      sw  = '0;
      if (apb.PSEL && apb.PENABLE) begin
        model_access(apb.PWRITE, apb.PADDR, rd, err);
        w = int'(apb.PADDR[4:2]);
        if (!err) begin
          if (apb.PWRITE && w == 1) m_en   = apb.PWDATA[NUM_SRC-1:0];
          if (apb.PWRITE && w == 2) m_trig = apb.PWDATA[NUM_SRC-1:0];
          if (apb.PWRITE && w == 4) sw     = apb.PWDATA[NUM_SRC-1:0];
          if (!apb.PWRITE && w == 3 && rd != 0) clr[rd-1] = 1'b1;
        end
      end
      m_pend = (m_pend & ~clr) | hw | sw;
      m_prev = eff;
      m_irq  = nirq;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err,
                          output logic [31:0] exp_rd, output logic exp_err);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wd;
    step();
    apb.PENABLE = 1'b1;
    #1;
    rd  = apb.PRDATA;
    err = apb.PSLVERR;
    model_access(wr, addr, exp_rd, exp_err);
    step();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    $display("apb wr=%0b addr=%h wdata=%h rdata=%h slverr=%b irq=%b", wr, addr, wd, rd, err, irq_o);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [31:0] rd, erd;
  logic er, eer;

  task automatic test_reset();
    logic [ADDR_W-1:0] a;
    src_i = '0;
    do_reset();
    total++;
    if (irq_o !== 1'b0 || apb.PRDATA !== 32'h0 || apb.PSLVERR !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got irq=%b prdata=%h slverr=%b want 0/0/0", irq_o, apb.PRDATA, apb.PSLVERR);
    end
    for (int i = 0; i < 4; i++) begin
      a = ADDR_W'(i * 4);
      apb_xfer(1'b0, a, 32'h0, rd, er, erd, eer);
      total++;
      if (rd !== 32'h0 || er !== 1'b0 || irq_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_read_%h: got rd=%h err=%b irq=%b want 0/0/0", a, rd, er, irq_o);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 12'h004; apb.PWDATA = 32'h0A;
    step();
    apb.PENABLE = 1'b1;
    reset = 1'b1;
    step();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    reset = 1'b0;
    step();
    apb_xfer(1'b0, 12'h004, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_access: got enable=%h err=%b want 0/0", rd, er);
    end
  endtask

  task automatic test_edge_claim();
    apb_xfer(1'b1, 12'h004, 32'h1F, rd, er, erd, eer);
    apb_xfer(1'b1, 12'h008, 32'h1F, rd, er, erd, eer);
    src_i = 5'b00100;
    step();
    src_i = '0;
    repeat (SYNC_DEPTH) step();
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL edge_irq_early: got irq=%b want 0", irq_o);
    end
    step();
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL edge_irq_latency: got irq=%b want 1", irq_o);
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h04 || er !== 1'b0) begin
      bad++;
      $display("FAIL edge_pending: got rd=%h err=%b want 04/0", rd, er);
    end
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'd3 || irq_o !== 1'b1) begin
      bad++;
      $display("FAIL edge_claim: got id=%0d irq=%b want 3/1", rd, irq_o);
    end
    step();
    total++;
    if (irq_o !== 1'b0) begin
      bad++;
      $display("FAIL edge_irq_drop: got irq=%b want 0", irq_o);
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL edge_pending_cleared: got %h want 0", rd);
    end
  endtask

  task automatic test_level_claim();
    apb_xfer(1'b1, 12'h008, 32'h0, rd, er, erd, eer);
    src_i = 5'b00001;
    repeat (SYNC_DEPTH + 2) step();
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'd1) begin
      bad++;
      $display("FAIL level_claim_held: got id=%0d want 1", rd);
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h01) begin
      bad++;
      $display("FAIL level_repend: got pending=%h want 01", rd);
    end
    src_i = '0;
    repeat (SYNC_DEPTH + 1) step();
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'd1) begin
      bad++;
      $display("FAIL level_claim_dropped: got id=%0d want 1", rd);
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL level_cleared: got pending=%h want 0", rd);
    end
  endtask

  task automatic test_swset_claims();
    logic [31:0] want[3];
    want[0] = 32'd2; want[1] = 32'd3; want[2] = 32'd0;
    apb_xfer(1'b1, 12'h004, 32'h06, rd, er, erd, eer);
    apb_xfer(1'b1, 12'h010, 32'h16, rd, er, erd, eer);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h16) begin
      bad++;
      $display("FAIL swset_pending: got %h want 16", rd);
    end
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, erd, eer);
      total++;
      if (rd !== want[i]) begin
        bad++;
        $display("FAIL swset_claim_%0d: got id=%0d want %0d", i, rd, want[i]);
      end
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h10 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL swset_remaining: got pending=%h irq=%b want 10/0", rd, irq_o);
    end
  endtask

  task automatic test_errors();
    apb_xfer(1'b1, 12'h000, 32'hFF, rd, er, erd, eer);
    total++;
    if (er !== 1'b1) begin
      bad++;
      $display("FAIL err_write_pending: got slverr=%b want 1", er);
    end
    apb_xfer(1'b1, 12'h00C, 32'hFF, rd, er, erd, eer);
    total++;
    if (er !== 1'b1) begin
      bad++;
      $display("FAIL err_write_claim: got slverr=%b want 1", er);
    end
    apb_xfer(1'b0, 12'h014, 32'h0, rd, er, erd, eer);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_read_0x14: got slverr=%b rd=%h want 1/0", er, rd);
    end
    apb_xfer(1'b1, 12'h01C, 32'h1F, rd, er, erd, eer);
    total++;
    if (er !== 1'b1) begin
      bad++;
      $display("FAIL err_write_0x1c: got slverr=%b want 1", er);
    end
    apb_xfer(1'b0, 12'h010, 32'h0, rd, er, erd, eer);
    total++;
    if (er !== 1'b1) begin
      bad++;
      $display("FAIL err_read_swset: got slverr=%b want 1", er);
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h10 || er !== 1'b0) begin
      bad++;
      $display("FAIL err_no_state_change: got pending=%h err=%b want 10/0", rd, er);
    end
    apb_xfer(1'b0, 12'h004, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h06) begin
      bad++;
      $display("FAIL err_enable_kept: got enable=%h want 06", rd);
    end
  endtask

  task automatic test_set_wins();
    apb_xfer(1'b1, 12'h004, 32'h1F, rd, er, erd, eer);
    apb_xfer(1'b1, 12'h008, 32'h1F, rd, er, erd, eer);
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'd5) begin
      bad++;
      $display("FAIL setwins_pre_claim: got id=%0d want 5", rd);
    end
    apb_xfer(1'b1, 12'h010, 32'h02, rd, er, erd, eer);
    // Raw rise timed so the synchronised edge lands on the claim's final edge.
    if (SYNC_DEPTH >= 2) begin
      src_i = 5'b00010;
      repeat (SYNC_DEPTH - 1) step();
    end
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 12'h00C; apb.PWDATA = '0;
    if (SYNC_DEPTH == 1) src_i = 5'b00010;
    step();
    apb.PENABLE = 1'b1;
    if (SYNC_DEPTH == 0) src_i = 5'b00010;
    #1;
    rd = apb.PRDATA;
    step();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    $display("apb wr=0 addr=00c (claim with rising src1) rdata=%h", rd);
    total++;
    if (rd !== 32'd2) begin
      bad++;
      $display("FAIL setwins_claim: got id=%0d want 2", rd);
    end
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h02) begin
      bad++;
      $display("FAIL setwins_pending: got %h want 02", rd);
    end
    src_i = '0;
    repeat (SYNC_DEPTH + 1) step();
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, erd, eer);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, erd, eer);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL setwins_edge_stays_clear: got %h want 0", rd);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic wr;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      src_i = NUM_SRC'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        step();
        total++;
        if (irq_o !== m_irq) begin
          bad++;
          $display("FAIL rand_irq_%0d: got irq=%b want %b", n, irq_o, m_irq);
        end
      end else begin
        a  = ADDR_W'($urandom);
        wr = 1'($urandom);
        apb_xfer(wr, a, $urandom, rd, er, erd, eer);
        total++;
        if (rd !== erd || er !== eer) begin
          bad++;
          $display("FAIL rand_apb_%0d: got rd=%h err=%b want rd=%h err=%b", n, rd, er, erd, eer);
        end
      end
    end
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    src_i = '0;
    reset = 1'b1;
    test_reset();
    test_reset_mid_access();
    test_edge_claim();
    test_level_claim();
    test_swset_claims();
    test_errors();
    test_set_wins();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
